mem_arbiter: RTL and testbench

Shares a single downstream memory port between the core's instruction-fetch interface (read-only) and data interface (read/write, byte-enabled). It sits between `core` and the unified memory model or cache in the system wrapper. It also sequences one outstanding transaction at a time, arbitrates round-robin on contention, and aborts stalled transactions with a timeout.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_rr_arbiter2.sv | 28 ++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arbiter_pkg : shared state and owner types for the memory arbiter
// Revision 1.0
// ============================================================================
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// rr_arbiter2 : combinational 2-way round-robin grant (bit 0 inst, bit 1 data)
// Revision 1.0
// ============================================================================
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_grant,
  output logic       grant_valid,
  output owner_t     grant
);

  always_comb begin
    grant_valid = |req;
    grant       = OWN_INST;
    case (req)
      2'b01:   grant = OWN_INST;
      2'b10:   grant = OWN_DATA;
      // On a tie the side that did not win last time goes first
      2'b11:   grant = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
      default: grant = OWN_INST;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one memory port between fetch and data, one txn at a time
// Revision 1.0
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_req,
  input  logic [DATA_WIDTH-1:0]      inst_addr,
  output logic                       inst_valid,
  output logic [DATA_WIDTH-1:0]      inst_data,
  input  logic                       data_req,
  input  logic                       data_we,
  input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
  input  logic [DATA_WIDTH-1:0]      data_addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic                       data_valid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [BYTE_DATA_WIDTH-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic                       mem_valid,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic                       bus_error
);

  localparam int                   C_CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [C_CNT_W-1:0]   C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  owner_t             r_owner;
  owner_t             r_last_grant;
  owner_t             w_grant;
  logic               w_grant_valid;
  logic               w_capture;
  logic               w_timeout;
  logic [C_CNT_W-1:0] r_cnt;

  rr_arbiter2 u_rr (
    .req         ({data_req, inst_req}),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant       (w_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // A response arriving on the timeout cycle takes priority over the abort
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: if (w_grant_valid) w_state_nxt = WAIT;
      WAIT: begin
        if (mem_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end else if (r_cnt == C_CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= OWN_INST;
      r_last_grant <= OWN_INST;
      r_cnt        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      inst_valid   <= 1'b0;
      data_valid   <= 1'b0;
      bus_error    <= 1'b0;
      inst_data    <= '0;
      rdata        <= '0;
    end else begin
      inst_valid <= 1'b0;
      data_valid <= 1'b0;
      bus_error  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_owner <= w_grant;
            r_cnt   <= '0;
            mem_req <= 1'b1;
            if (w_grant == OWN_DATA) begin
              mem_we    <= data_we;
              mem_be    <= byte_enable;
              mem_addr  <= data_addr;
              mem_wdata <= wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_be    <= '1;
              mem_addr  <= inst_addr;
              mem_wdata <= '0;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + C_CNT_W'(1);
          if (w_capture || w_timeout) begin
            mem_req   <= 1'b0;
            r_cnt     <= '0;
            bus_error <= w_timeout;
            if (r_owner == OWN_INST) begin
              inst_valid <= 1'b1;
              inst_data  <= w_capture ? mem_rdata : '0;
            end else begin
              data_valid <= 1'b1;
              rdata      <= (w_capture && !mem_we) ? mem_rdata : '0;
            end
          end
        end
        RESP: begin
          r_last_grant <= r_owner;
          r_cnt        <= '0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : self-checking bench for mem_arbiter with a reference model
// Revision 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic          inst_req;
  logic [DW-1:0] inst_addr;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic          data_req;
  logic          data_we;
  logic [BW-1:0] byte_enable;
  logic [DW-1:0] data_addr;
  logic [DW-1:0] wdata;
  logic          data_valid;
  logic [DW-1:0] rdata;
  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_valid;
  logic [DW-1:0] mem_rdata;
  logic          bus_error;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations of one transaction, filled by mem_respond
  bit            obs_ok, obs_stable, obs_iv, obs_dv, obs_err, obs_hold, obs_mreq, obs_we;
  int            obs_k, obs_wait;
  logic [BW-1:0] obs_be;
  logic [DW-1:0] obs_addr, obs_wdata, obs_idata, obs_rdata;
  bit            scramble = 1'b0;
  bit            model_last_data = 1'b0;

  mem_arbiter #(
    .DATA_WIDTH      (DW),
    .BYTE_DATA_WIDTH (BW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .data_req    (data_req),
    .data_we     (data_we),
    .byte_enable (byte_enable),
    .data_addr   (data_addr),
    .wdata       (wdata),
    .data_valid  (data_valid),
    .rdata       (rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_valid   (mem_valid),
    .mem_rdata   (mem_rdata),
    .bus_error   (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Memory responder: waits for mem_req, answers after lat cycles (never if lat >= TO),
  // then records the response seen by the core side.
  task automatic mem_respond(input int lat, input logic [DW-1:0] rdv);
    int k;
    obs_ok = 0; obs_stable = 1; obs_iv = 0; obs_dv = 0; obs_err = 0; obs_hold = 0; obs_k = -1;
    k = 0;
    while (mem_req !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    obs_wait = k;
    if (mem_req !== 1'b1) return;
    obs_we = mem_we; obs_be = mem_be; obs_addr = mem_addr; obs_wdata = mem_wdata;
    for (k = 0; k < 40; k++) begin
      if (inst_valid || data_valid) break;
      if (mem_req && (mem_we !== obs_we || mem_be !== obs_be ||
                      mem_addr !== obs_addr || mem_wdata !== obs_wdata)) obs_stable = 0;
      if (scramble) begin
        inst_addr = $urandom; data_addr = $urandom; wdata = $urandom;
        byte_enable = 4'($urandom_range(0, 15));
      end
      mem_valid = (k == lat);
      mem_rdata = (k == lat) ? rdv : DW'($urandom);
      @(negedge clk);
    end
    mem_valid = 1'b0;
    if (inst_valid || data_valid) begin
      obs_ok = 1; obs_k = k; obs_iv = inst_valid; obs_dv = data_valid; obs_err = bus_error;
      obs_idata = inst_data; obs_rdata = rdata; obs_mreq = mem_req;
      @(negedge clk);
      obs_hold = inst_valid | data_valid | bus_error;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if ({mem_req, mem_we, inst_valid, data_valid, bus_error} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, inst_valid, data_valid, bus_error}); end
    n_tests++; if ({mem_be, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_mem_fields: be=%h addr=%h wdata=%h want 0", mem_be, mem_addr, mem_wdata); end
    n_tests++; if ({inst_data, rdata} !== '0) begin
      n_fail++; $display("FAIL reset_rdata: inst_data=%h rdata=%h want 0", inst_data, rdata); end
    inst_req = 1'b1; data_req = 1'b1;
    @(negedge clk);
    n_tests++; if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_blocks_req: mem_req=%b want 0", mem_req); end
    inst_req = 1'b0; data_req = 1'b0;
    rst = 1'b0;
    model_last_data = 1'b0;
  endtask

  task automatic test_contention();
    bit want_data;
    inst_addr = 32'h1000; data_addr = 32'h2000; data_we = 1'b0; byte_enable = 4'h5;
    inst_req = 1'b1; data_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      want_data = (t % 2 == 0);
      mem_respond(0, 32'hA0 + 32'(t));
      n_tests++; if (obs_addr !== (want_data ? 32'h2000 : 32'h1000)) begin
        n_fail++; $display("FAIL contention_order[%0d]: mem_addr=%h want %h", t, obs_addr, want_data ? 32'h2000 : 32'h1000); end
      n_tests++; if (obs_dv !== want_data || obs_iv !== !want_data) begin
        n_fail++; $display("FAIL contention_valid[%0d]: iv=%b dv=%b want dv=%b", t, obs_iv, obs_dv, want_data); end
      n_tests++; if (obs_k !== 1) begin
        n_fail++; $display("FAIL contention_latency[%0d]: %0d want 1", t, obs_k); end
    end
    inst_req = 1'b0; data_req = 1'b0;
    model_last_data = 1'b0;
  endtask

  task automatic test_lone_fetch();
    inst_addr = 32'h100; inst_req = 1'b1;
    mem_respond(2, 32'hDEADBEEF);
    inst_req = 1'b0;
    n_tests++; if (!obs_ok || obs_wait !== 1) begin
      n_fail++; $display("FAIL fetch_start: ok=%b mem_req after %0d cycles want 1", obs_ok, obs_wait); end
    n_tests++; if (obs_addr !== 32'h100 || obs_we !== 1'b0 || obs_be !== 4'hF) begin
      n_fail++; $display("FAIL fetch_fields: addr=%h we=%b be=%h want 100/0/f", obs_addr, obs_we, obs_be); end
    n_tests++; if (obs_iv !== 1'b1 || obs_dv !== 1'b0 || obs_idata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL fetch_resp: iv=%b dv=%b data=%h want 1/0/deadbeef", obs_iv, obs_dv, obs_idata); end
    n_tests++; if (obs_k !== 3 || obs_hold !== 1'b0 || obs_err !== 1'b0) begin
      n_fail++; $display("FAIL fetch_timing: k=%0d hold=%b err=%b want 3/0/0", obs_k, obs_hold, obs_err); end
    model_last_data = 1'b0;
  endtask

  task automatic test_write();
    data_addr = 32'h200; wdata = 32'h12345678; byte_enable = 4'b0011; data_we = 1'b1;
    data_req = 1'b1; scramble = 1'b1;
    mem_respond(3, 32'hCAFEF00D);
    scramble = 1'b0; data_req = 1'b0;
    n_tests++; if (obs_we !== 1'b1 || obs_be !== 4'b0011 || obs_addr !== 32'h200 || obs_wdata !== 32'h12345678) begin
      n_fail++; $display("FAIL write_fields: we=%b be=%b addr=%h wdata=%h", obs_we, obs_be, obs_addr, obs_wdata); end
    n_tests++; if (obs_stable !== 1'b1) begin
      n_fail++; $display("FAIL write_stable: mem fields changed during wait (got %b want 1)", obs_stable); end
    n_tests++; if (obs_dv !== 1'b1 || obs_iv !== 1'b0 || obs_rdata !== '0 || obs_hold !== 1'b0) begin
      n_fail++; $display("FAIL write_resp: dv=%b iv=%b rdata=%h hold=%b want 1/0/0/0", obs_dv, obs_iv, obs_rdata, obs_hold); end
    model_last_data = 1'b1;
  endtask

  task automatic test_timeout();
    data_addr = 32'h240; data_we = 1'b0; byte_enable = 4'hF; data_req = 1'b1;
    mem_respond(1000, 32'h11111111);
    data_req = 1'b0;
    n_tests++; if (!obs_ok || obs_k !== TO) begin
      n_fail++; $display("FAIL timeout_cycle: ok=%b valid after %0d want %0d", obs_ok, obs_k, TO); end
    n_tests++; if (obs_dv !== 1'b1 || obs_err !== 1'b1 || obs_rdata !== '0) begin
      n_fail++; $display("FAIL timeout_resp: dv=%b err=%b rdata=%h want 1/1/0", obs_dv, obs_err, obs_rdata); end
    n_tests++; if (obs_mreq !== 1'b0 || obs_hold !== 1'b0) begin
      n_fail++; $display("FAIL timeout_idle: mem_req=%b hold=%b want 0/0", obs_mreq, obs_hold); end
    model_last_data = 1'b1;
  endtask

  task automatic test_timeout_tie();
    data_addr = 32'h280; data_we = 1'b0; data_req = 1'b1;
    mem_respond(TO - 1, 32'h0BADCAFE);
    data_req = 1'b0;
    n_tests++; if (!obs_ok || obs_k !== TO || obs_err !== 1'b0) begin
      n_fail++; $display("FAIL tie_err: ok=%b k=%0d err=%b want k=%0d err=0", obs_ok, obs_k, obs_err, TO); end
    n_tests++; if (obs_dv !== 1'b1 || obs_rdata !== 32'h0BADCAFE) begin
      n_fail++; $display("FAIL tie_data: dv=%b rdata=%h want 1/0badcafe", obs_dv, obs_rdata); end
    model_last_data = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    int k;
    data_addr = 32'h300; data_we = 1'b0; data_req = 1'b1;
    mem_respond(1, 32'h55AA55AA);
    data_req = 1'b0;
    n_tests++; if (obs_dv !== 1'b1 || obs_rdata !== 32'h55AA55AA) begin
      n_fail++; $display("FAIL rstwait_pre: dv=%b rdata=%h want 1/55aa55aa", obs_dv, obs_rdata); end
    data_addr = 32'h304; data_req = 1'b1;
    k = 0;
    while (mem_req !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    n_tests++; if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rstwait_req: mem_req=%b want 1", mem_req); end
    @(negedge clk);
    rst = 1'b1; data_req = 1'b0;
    @(negedge clk);
    n_tests++; if ({mem_req, mem_we, inst_valid, data_valid, bus_error} !== 5'b0 || mem_addr !== '0) begin
      n_fail++; $display("FAIL rstwait_clear: ctrl=%b addr=%h want 0/0", {mem_req, mem_we, inst_valid, data_valid, bus_error}, mem_addr); end
    rst = 1'b0; mem_valid = 1'b1; mem_rdata = 32'hFEEDFACE;
    @(negedge clk);
    mem_valid = 1'b0;
    n_tests++; if ({mem_req, inst_valid, data_valid, bus_error} !== 4'b0) begin
      n_fail++; $display("FAIL rstwait_stale1: ctrl=%b want 0000", {mem_req, inst_valid, data_valid, bus_error}); end
    @(negedge clk);
    n_tests++; if ({mem_req, inst_valid, data_valid, rdata} !== '0) begin
      n_fail++; $display("FAIL rstwait_stale2: req=%b iv=%b dv=%b rdata=%h want 0", mem_req, inst_valid, data_valid, rdata); end
    inst_addr = 32'h400; data_addr = 32'h500; inst_req = 1'b1; data_req = 1'b1;
    mem_respond(0, 32'h77);
    data_req = 1'b0;
    n_tests++; if (obs_addr !== 32'h500 || obs_dv !== 1'b1) begin
      n_fail++; $display("FAIL rstwait_tie: addr=%h dv=%b want 500/1", obs_addr, obs_dv); end
    mem_respond(0, 32'h88);
    inst_req = 1'b0;
    n_tests++; if (obs_addr !== 32'h400 || obs_iv !== 1'b1 || obs_idata !== 32'h88) begin
      n_fail++; $display("FAIL rstwait_next: addr=%h iv=%b data=%h want 400/1/88", obs_addr, obs_iv, obs_idata); end
    model_last_data = 1'b0;
  endtask

  task automatic test_random();
    bit            exp_data, exp_we, exp_err;
    logic [BW-1:0] exp_be;
    logic [DW-1:0] exp_addr, exp_wdata, exp_resp, rdv, got_resp;
    int            lat, exp_k;
    inst_req = 1'b0; data_req = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!inst_req) begin
        inst_req = 1'($urandom_range(0, 1)); inst_addr = $urandom;
      end
      if (!data_req) begin
        data_req = 1'($urandom_range(0, 1)); data_addr = $urandom; wdata = $urandom;
        data_we = 1'($urandom_range(0, 1)); byte_enable = 4'($urandom_range(0, 15));
      end
      if (!inst_req && !data_req) data_req = 1'b1;
      exp_data  = (inst_req && data_req) ? !model_last_data : data_req;
      exp_addr  = exp_data ? data_addr : inst_addr;
      exp_we    = exp_data ? data_we : 1'b0;
      exp_be    = exp_data ? byte_enable : 4'hF;
      exp_wdata = exp_data ? wdata : '0;
      lat       = $urandom_range(0, TO + 1);
      rdv       = $urandom;
      exp_err   = (lat >= TO);
      exp_k     = exp_err ? TO : lat + 1;
      exp_resp  = (exp_err || (exp_data && exp_we)) ? '0 : rdv;
      mem_respond(lat, rdv);
      got_resp = exp_data ? obs_rdata : obs_idata;
      n_tests++; if (!obs_ok || obs_wait !== 1) begin
        n_fail++; $display("FAIL rand[%0d]_start: ok=%b wait=%0d want 1", n, obs_ok, obs_wait); end
      n_tests++; if (obs_addr !== exp_addr || obs_we !== exp_we || obs_be !== exp_be || obs_wdata !== exp_wdata) begin
        n_fail++; $display("FAIL rand[%0d]_fields: addr=%h we=%b be=%h wd=%h want %h/%b/%h/%h",
                           n, obs_addr, obs_we, obs_be, obs_wdata, exp_addr, exp_we, exp_be, exp_wdata); end
      n_tests++; if (obs_dv !== exp_data || obs_iv !== !exp_data) begin
        n_fail++; $display("FAIL rand[%0d]_owner: iv=%b dv=%b want dv=%b", n, obs_iv, obs_dv, exp_data); end
      n_tests++; if (obs_err !== exp_err || obs_k !== exp_k) begin
        n_fail++; $display("FAIL rand[%0d]_timing: err=%b k=%0d want %b/%0d", n, obs_err, obs_k, exp_err, exp_k); end
      n_tests++; if (got_resp !== exp_resp) begin
        n_fail++; $display("FAIL rand[%0d]_data: got %h want %h", n, got_resp, exp_resp); end
      n_tests++; if (obs_hold !== 1'b0 || obs_stable !== 1'b1 || obs_mreq !== 1'b0) begin
        n_fail++; $display("FAIL rand[%0d]_pulse: hold=%b stable=%b mreq=%b want 0/1/0", n, obs_hold, obs_stable, obs_mreq); end
      model_last_data = exp_data;
      if (exp_data) data_req = 1'b0;
      else          inst_req = 1'b0;
    end
    inst_req = 1'b0; data_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_we = 1'b0;
    byte_enable = '0; data_addr = '0; wdata = '0; mem_valid = 1'b0; mem_rdata = '0;
    test_reset();
    test_contention();
    test_lone_fetch();
    test_write();
    test_timeout();
    test_timeout_tie();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
